bus_transfer_sequencer: RTL and testbench
=========================================

# bus_transfer_sequencer

Control stage directly upstream of the buffered bus registers: it generates the per-register `enable` (bus drive) and `latch` (capture) strobes for one register-to-register move over the shared 16-bit bus. The block accepts a transfer command (source index, destination index, settle count) over a valid/ready handshake. It then walks a fixed drive → latch → release sequence. At most one register drives the bus at any time, and the destination captures only while the source is driving.

## Interface
Parameters:
- `NUM_REGS`, 8: number of bus registers controlled; width of the strobe vectors.
- `IDX_W`, 3: width of the source/destination index fields; `2**IDX_W >= NUM_REGS`.

Ports:
- `clk`  input  1  single system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  block can accept a command.
- `cmd_src`  input  IDX_W  index of the register that drives the bus.
- `cmd_dst`  input  IDX_W  index of the register that latches from the bus.
- `cmd_settle`  input  2  extra drive-only cycles before latching (0–3).
- `enable`  output  NUM_REGS  one-hot-or-zero bus-drive strobes, one per register.
- `latch`  output  NUM_REGS  one-hot-or-zero capture strobes, one per register.
- `busy`  output  1  transfer in progress (any state other than IDLE).
- `done`  output  1  one-cycle pulse when a transfer completes.
- `err`  output  1  one-cycle reject pulse; tied 0 unless the macro is defined.

## Operation
- Accept: a command is accepted on a rising edge where `cmd_valid && cmd_ready`. The block captures `cmd_src`, `cmd_dst` and `cmd_settle` at that edge.
- States: IDLE → DRIVE → LATCH → RELEASE → IDLE. The REJECT state exists only with the macro.
- IDLE:
  - `cmd_ready=1`.
  - All strobes 0, `busy=0`.
- DRIVE:
  - `enable[src]=1`, `latch=0`.
  - Held for 1+settle cycles, counted by an internal 2-bit down-counter.
- LATCH:
  - `enable[src]=1`, `latch[dst]=1`, for exactly one cycle.
  - The destination register captures the bus at the edge ending this cycle.
- RELEASE:
  - All strobes 0, `done=1` for one cycle.
  - Returns to IDLE.
- Outputs are registered. Strobes never glitch between states.
- Invariants:
  - `$countones(enable) <= 1` and `$countones(latch) <= 1`.
  - `latch[dst]` is never high unless `enable[src]` is high in the same cycle.
- Commands arriving while `busy` are not accepted, because `cmd_ready=0`. The command is held by the producer.
- An index `>= NUM_REGS` decodes to no bit, so the corresponding vector stays zero.
- `src==dst` (macro absent): the sequence runs normally, and the register reloads its own value.

## Timing
- Reset values (`rst_n` low, asynchronous): state IDLE, `enable=0`, `latch=0`, `busy=0`, `done=0`, `err=0`, `cmd_ready=0`.
- `cmd_ready` rises on the first rising edge after `rst_n` deasserts.
- Transfer timeline, with the accept edge at cycle T:
  - DRIVE occupies cycles T+1 … T+1+settle.
  - LATCH occurs at T+2+settle.
  - RELEASE with `done` occurs at T+3+settle.
  - `cmd_ready=1` again at T+4+settle.
- Minimum transfer is 4 cycles, accept to next accept.
- Reset mid-transfer: all strobes drop to 0 immediately and the captured command is discarded. No `done` or `err` is produced.

## Configuration
- `BUS_SEQ_CHECK_EN` defined:
  - A command with `src==dst`, `src>=NUM_REGS` or `dst>=NUM_REGS` is accepted, then goes to REJECT.
  - REJECT lasts one cycle: `err=1`, all strobes 0, no `done`.
  - The block returns to IDLE, with `cmd_ready=1` at T+2.
- Not defined:
  - No REJECT state; `err` is constant 0.
  - Illegal commands run the normal sequence with the zero-decode behaviour described in Operation.

## Test plan
- Reset: hold `rst_n=0` while toggling `clk` → all outputs 0. After release, `cmd_ready=1` on the next edge.
- Basic move, src=2, dst=5, settle=0, accept at T:
  - `enable=8'h04` at T+1.
  - `enable=8'h04` and `latch=8'h20` at T+2.
  - `done=1` and strobes 0 at T+3.
  - `cmd_ready=1` at T+4.
- Settle, src=1, dst=0, settle=3:
  - `enable=8'h02` for 4 cycles, then a single `latch=8'h01` cycle.
  - `done` at T+6.
- Back-to-back: `cmd_valid` held high with two commands → second accepted exactly at T+4. The one-hot invariant holds throughout, and `cmd_valid` is ignored while busy.
- Reset mid-transfer: assert `rst_n=0` during DRIVE → `enable` returns to 0 asynchronously, before the next edge. No `done` follows.
- With `BUS_SEQ_CHECK_EN`, src=dst=3:
  - `err=1` at T+1, and `enable` and `latch` stay 0.
  - `cmd_ready=1` at T+2.
  - Without the macro, the same command yields `enable=latch=8'h08` at T+2 and `done` at T+3.

Source files
------------

// File: rtl/bus_transfer_sequencer_if.sv
// Command/strobe bundle for bus_transfer_sequencer.
// master = command producer / strobe consumer; slave = the sequencer.
interface bus_transfer_sequencer_if #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IDX_W-1:0]    cmd_src;
  logic [IDX_W-1:0]    cmd_dst;
  logic [1:0]          cmd_settle;
  logic [NUM_REGS-1:0] enable;
  logic [NUM_REGS-1:0] latch;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_settle,
    input  cmd_ready, enable, latch, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_settle,
    output cmd_ready, enable, latch, busy, done, err
  );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// bus_transfer_sequencer: drives per-register enable/latch strobes for one
// register-to-register move over the shared bus (drive -> latch -> release).
// All outputs are registered from next-state values, so they change only on
// the clock edge (or asynchronously to zero on reset).
// Optional macro BUS_SEQ_CHECK_EN: reject src==dst or out-of-range indices
// through a one-cycle REJECT state that pulses err.
module bus_transfer_sequencer #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  bus_transfer_sequencer_if.slave bus
);

`ifdef BUS_SEQ_CHECK_EN
  typedef enum logic [2:0] {IDLE, DRIVE, LATCH, RELEASE, REJECT} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, RELEASE} state_t;
`endif

  state_t              state, state_n;
  logic [IDX_W-1:0]    src_q, src_n;
  logic [IDX_W-1:0]    dst_q, dst_n;
  logic [1:0]          cnt_q, cnt_n;
  logic                accept;
  logic [NUM_REGS-1:0] en_n, lt_n;
  logic                done_n;
`ifdef BUS_SEQ_CHECK_EN
  logic                illegal;
  logic                err_n;
`endif

  // Index to one-hot; indices >= NUM_REGS match no bit and decode to zero.
  function automatic logic [NUM_REGS-1:0] dec(input logic [IDX_W-1:0] idx);
    dec = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == IDX_W'(i)) dec[i] = 1'b1;
  endfunction

  assign accept = bus.cmd_valid && bus.cmd_ready;

`ifdef BUS_SEQ_CHECK_EN
  // Legal only when both indices hit a register and they differ.
  assign illegal = (bus.cmd_src == bus.cmd_dst) || ~|dec(bus.cmd_src) || ~|dec(bus.cmd_dst);
`endif

  // Next-state, command capture and next-cycle strobe values.
  always_comb begin
    state_n = state;
    src_n   = src_q;
    dst_n   = dst_q;
    cnt_n   = cnt_q;
    case (state)
      IDLE: if (accept) begin
        src_n = bus.cmd_src;
        dst_n = bus.cmd_dst;
        cnt_n = bus.cmd_settle;
`ifdef BUS_SEQ_CHECK_EN
        state_n = illegal ? REJECT : DRIVE;
`else
        state_n = DRIVE;
`endif
      end
      DRIVE: begin
        if (cnt_q == 2'd0) state_n = LATCH;
        else               cnt_n   = cnt_q - 2'd1;
      end
      LATCH:   state_n = RELEASE;
      RELEASE: state_n = IDLE;
`ifdef BUS_SEQ_CHECK_EN
      REJECT:  state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase

    en_n   = '0;
    lt_n   = '0;
    done_n = 1'b0;
`ifdef BUS_SEQ_CHECK_EN
    err_n  = 1'b0;
`endif
    case (state_n)
      DRIVE: en_n = dec(src_n);
      LATCH: begin
        en_n = dec(src_n);
        // A destination never captures a bus nobody drives (out-of-range src).
        lt_n = dec(dst_n) & {NUM_REGS{|en_n}};
      end
      RELEASE: done_n = 1'b1;
`ifdef BUS_SEQ_CHECK_EN
      REJECT:  err_n  = 1'b1;
`endif
      default: ;
    endcase
  end

  // State, captured command and registered outputs; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      cnt_q         <= '0;
      bus.enable    <= '0;
      bus.latch     <= '0;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.cmd_ready <= 1'b0;
    end else begin
      state         <= state_n;
      src_q         <= src_n;
      dst_q         <= dst_n;
      cnt_q         <= cnt_n;
      bus.enable    <= en_n;
      bus.latch     <= lt_n;
      bus.done      <= done_n;
      bus.busy      <= (state_n != IDLE);
      bus.cmd_ready <= (state_n == IDLE);
    end
  end

`ifdef BUS_SEQ_CHECK_EN
  // Reject pulse, registered alongside the strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.err <= 1'b0;
    else        bus.err <= err_n;
  end
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench for bus_transfer_sequencer: stimulus pushes the expected
// strobe/done/err events (with the cycle they must appear in) into a queue,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_bus_transfer_sequencer;
  localparam int NUM_REGS = 8;
  localparam int IDX_W    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_transfer_sequencer_if #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) bus();

  bus_transfer_sequencer #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int       cyc;
    logic [7:0] en;
    logic [7:0] lt;
    logic     done;
    logic     err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle with visible activity must match the next expected event.
  always @(negedge clk) begin
    if (rst_n && (bus.enable != 8'h00 || bus.latch != 8'h00 || bus.done || bus.err)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: cyc %0d en %h lt %h done %b err %b", cyc, bus.enable, bus.latch, bus.done, bus.err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.en !== bus.enable || e.lt !== bus.latch || e.done !== bus.done || e.err !== bus.err) begin
          errors++;
          $display("FAIL sb_event: got cyc %0d en %h lt %h done %b err %b expected cyc %0d en %h lt %h done %b err %b",
                   cyc, bus.enable, bus.latch, bus.done, bus.err, e.cyc, e.en, e.lt, e.done, e.err);
        end
      end
    end
  end

  // Invariants: one-hot-or-zero strobes, latch only while something drives.
  always @(negedge clk) begin
    if (rst_n && (bus.enable != 8'h00 || bus.latch != 8'h00)) begin
      checks++;
      if ($countones(bus.enable) > 1 || $countones(bus.latch) > 1 || (bus.latch != 8'h00 && bus.enable == 8'h00)) begin
        errors++;
        $display("FAIL invariant: en %h lt %h (cyc %0d)", bus.enable, bus.latch, cyc);
      end
    end
  end

  // Present a command from a negedge until accepted; acc = cyc of the first DRIVE cycle.
  task automatic send(input logic [2:0] s, input logic [2:0] d, input logic [1:0] st, output int acc);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_src    = s;
    bus.cmd_dst    = d;
    bus.cmd_settle = st;
    while (bus.cmd_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready %b expected 1", bus.cmd_ready);
      acc = -100;
      return;
    end
    @(posedge clk);
    #1 acc = cyc;
  endtask

  // Expected events of a normal transfer with hand-computed strobe vectors.
  task automatic push_xfer(input int acc, input int st, input logic [7:0] en, input logic [7:0] lt);
    for (int k = 0; k <= st; k++) sb.push_back('{acc + k, en, 8'h00, 1'b0, 1'b0});
    sb.push_back('{acc + st + 1, en, lt, 1'b0, 1'b0});
    sb.push_back('{acc + st + 2, 8'h00, 8'h00, 1'b1, 1'b0});
  endtask

  task automatic idle();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  int a, a1, a2, a3, w;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_src    = '0;
    bus.cmd_dst    = '0;
    bus.cmd_settle = '0;

    // Reset held while clocking: all outputs zero, including cmd_ready.
    repeat (3) @(negedge clk);
    chk("rst_enable", 32'(bus.enable), 32'h0);
    chk("rst_latch",  32'(bus.latch),  32'h0);
    chk("rst_busy",   32'(bus.busy),   32'h0);
    chk("rst_done",   32'(bus.done),   32'h0);
    chk("rst_err",    32'(bus.err),    32'h0);
    chk("rst_ready",  32'(bus.cmd_ready), 32'h0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 32'(bus.cmd_ready), 32'h0);
    @(posedge clk);
    #1 chk("ready_after_reset", 32'(bus.cmd_ready), 32'h1);

    // Basic move 2->5, settle 0; ready returns 4 cycles after accept.
    send(3'd2, 3'd5, 2'd0, a);
    push_xfer(a, 0, 8'h04, 8'h20);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("basic_busy_release", 32'(bus.busy), 32'h1);
    chk("basic_ready_release", 32'(bus.cmd_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("basic_ready_back", 32'(bus.cmd_ready), 32'h1);
    chk("basic_busy_idle", 32'(bus.busy), 32'h0);

    // Settle 3: four drive cycles, latch, done at accept+6.
    send(3'd1, 3'd0, 2'd3, a);
    push_xfer(a, 3, 8'h02, 8'h01);
    idle();
    repeat (8) @(posedge clk);

    // Back-to-back with cmd_valid held; later commands wait out the busy period.
    send(3'd2, 3'd5, 2'd0, a1);
    push_xfer(a1, 0, 8'h04, 8'h20);
    send(3'd1, 3'd0, 2'd3, a2);
    push_xfer(a2, 3, 8'h02, 8'h01);
    chk("b2b_gap_1", 32'(a2 - a1), 32'd4);
    send(3'd7, 3'd0, 2'd1, a3);
    push_xfer(a3, 1, 8'h80, 8'h01);
    chk("b2b_gap_2", 32'(a3 - a2), 32'd7);
    idle();
    repeat (8) @(posedge clk);

    // src == dst.
    send(3'd3, 3'd3, 2'd0, a);
`ifdef BUS_SEQ_CHECK_EN
    sb.push_back('{a, 8'h00, 8'h00, 1'b0, 1'b1});
    idle();
    @(posedge clk);
    #1 chk("reject_ready", 32'(bus.cmd_ready), 32'h1);
`else
    push_xfer(a, 0, 8'h08, 8'h08);
    idle();
    repeat (3) @(posedge clk);
    #1 chk("self_ready", 32'(bus.cmd_ready), 32'h1);
`endif
    repeat (4) @(posedge clk);

    // Reset during DRIVE: strobes drop asynchronously, no done afterwards.
    send(3'd4, 3'd6, 2'd3, a);
    sb.push_back('{a, 8'h10, 8'h00, 1'b0, 1'b0});
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_enable", 32'(bus.enable), 32'h0);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Recovery after reset: 0 -> 7, settle 2.
    send(3'd0, 3'd7, 2'd2, a);
    push_xfer(a, 2, 8'h01, 8'h80);
    idle();

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
